// File: rtl/ml_stage3_pkg.sv
// ml_stage3_pkg
//   Shared constants and types for the stage-3 result serializer.
//   - NUM_FIELDS / VEC_W / BEAT_W : vector geometry
//   - FIELD_LSB / FIELD_W         : bit position and width of each packed field
//   - state_t                     : serializer FSM states
//   - field_mask()                : low-bit mask used to zero-extend narrow fields
package ml_stage3_pkg;

    localparam int NUM_FIELDS = 11;
    localparam int VEC_W      = 86;
    localparam int BEAT_W     = 8;
    localparam int IDX_W      = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);

    localparam int FIELD_LSB [NUM_FIELDS] = '{0, 8, 14, 22, 30, 38, 46, 54, 62, 70, 78};
    localparam int FIELD_W   [NUM_FIELDS] = '{8, 6, 8, 8, 8, 8, 8, 8, 8, 8, 8};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Mask of the w low bits of a beat; w == BEAT_W yields all ones.
    function automatic logic [BEAT_W-1:0] field_mask(input int w);
        return ~({BEAT_W{1'b1}} << w);
    endfunction

endpackage

// File: rtl/ml_stage3_field_mux.sv
// ml_stage3_field_mux
//   Combinational selector returning packed field[idx] of the result vector,
//   zero-extended to one beat.
//   Ports:
//     vec   in  VEC_W  captured result vector
//     idx   in  IDX_W  field index 0..NUM_FIELDS-1
//     field out BEAT_W selected field, zero-extended (0 for out-of-range idx)
module ml_stage3_field_mux
    import ml_stage3_pkg::*;
(
    input  logic [VEC_W-1:0]  vec,
    input  logic [IDX_W-1:0]  idx,
    output logic [BEAT_W-1:0] field
);

    always_comb begin
        field = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (idx == IDX_W'(k)) begin
                field = BEAT_W'(vec >> FIELD_LSB[k]) & field_mask(FIELD_W[k]);
            end
        end
    end

endmodule

// File: rtl/ml_stage3_out_serializer.sv
// ml_stage3_out_serializer
//   Captures one 86-bit stage-3 result vector over a valid/ready slave port
//   into a single-entry buffer, then streams its 11 packed fields as byte
//   beats over an AXI-Stream-style master port.
//   Ports:
//     aclk      in   clock, rising edge
//     aresetn   in   asynchronous active-low reset
//     s_data    in   VEC_W  result vector
//     s_valid   in   s_data valid
//     s_ready   out  vector accepted this cycle (combinational from m_tready in SEND)
//     m_tdata   out  BEAT_W current field, zero-extended
//     m_tuser   out  4     field index of current beat
//     m_tlast   out  high on the final field beat
//     m_tvalid  out  beat valid
//     m_tready  in   downstream accepts beat
module ml_stage3_out_serializer
    import ml_stage3_pkg::*;
(
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [VEC_W-1:0]  s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [BEAT_W-1:0] m_tdata,
    output logic [3:0]        m_tuser,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VEC_W-1:0]   buf_q;
    logic               load;
    logic [BEAT_W-1:0]  field;

    ml_stage3_field_mux u_field_mux (
        .vec   (buf_q),
        .idx   (idx_q),
        .field (field)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        s_ready = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (idx_q > LAST_IDX) begin
                    // Unreachable index: abandon the vector rather than emit garbage.
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    // Accepting the next vector on the final beat keeps the stream gap-free.
                    s_ready = (idx_q == LAST_IDX) && m_tready;
                    if (m_tready) begin
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_q + 1'b1;
                        end else if (s_valid) begin
                            load  = 1'b1;
                            idx_d = '0;
                        end else begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load) begin
                buf_q <= s_data;
            end
        end
    end

    // Beat outputs are qualified by the registered state so IDLE presents zeros.
    assign m_tvalid = (state_q == SEND);
    assign m_tdata  = m_tvalid ? field : '0;
    assign m_tuser  = m_tvalid ? idx_q : '0;
    assign m_tlast  = m_tvalid && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_ml_stage3_out_serializer.sv
module tb_ml_stage3_out_serializer;
    import ml_stage3_pkg::*;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [VEC_W-1:0]  s_data;
    logic              s_valid;
    logic              s_ready;
    logic [BEAT_W-1:0] m_tdata;
    logic [3:0]        m_tuser;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]        fld [NUM_FIELDS];
    logic [VEC_W-1:0]  vecs [3];
    logic [7:0]        exp_b2b [33];
    logic [VEC_W-1:0]  v_tmp;
    int                next_idx;
    int                hs;
    int                cyc;
    logic [3:0]        bp_pat;

    ml_stage3_out_serializer dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_tdata  (m_tdata),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Hand layout: field0 [7:0], field1 [13:8], field k [14+8(k-2) +: 8].
    function automatic logic [VEC_W-1:0] pack_fld();
        logic [VEC_W-1:0] v;
        v = '0;
        v[7:0]  = fld[0];
        v[13:8] = fld[1][5:0];
        for (int k = 2; k < NUM_FIELDS; k++) v[14 + 8*(k-2) +: 8] = fld[k];
        return v;
    endfunction

    task automatic fill_seed(input logic [7:0] seed);
        for (int k = 0; k < NUM_FIELDS; k++) fld[k] = seed + 8'(k);
        fld[1] = fld[1] & 8'h3F;
    endtask

    task automatic check_beat(input string tag, input int i, input logic [7:0] d);
        chk($sformatf("%s tvalid %0d", tag, i), 32'(m_tvalid), 32'd1);
        chk($sformatf("%s tdata %0d", tag, i),  32'(m_tdata),  32'(d));
        chk($sformatf("%s tuser %0d", tag, i),  32'(m_tuser),  32'(i));
        chk($sformatf("%s tlast %0d", tag, i),  32'(m_tlast),  32'(i == 10));
    endtask

    initial begin
        aresetn  = 1'b0;
        s_data   = '0;
        s_valid  = 1'b0;
        m_tready = 1'b0;
        #12;
        chk("rst tvalid", 32'(m_tvalid), 32'd0);
        chk("rst tdata",  32'(m_tdata),  32'd0);
        chk("rst tuser",  32'(m_tuser),  32'd0);
        chk("rst tlast",  32'(m_tlast),  32'd0);
        tick();
        aresetn = 1'b1;
        #1;
        chk("rst s_ready", 32'(s_ready), 32'd1);
        tick();

        // Single vector, m_tready high.
        fld[0] = 8'h11;
        fld[1] = 8'h3F;
        for (int k = 2; k < NUM_FIELDS; k++) fld[k] = 8'hA0 + 8'(k);
        s_data   = pack_fld();
        s_valid  = 1'b1;
        m_tready = 1'b1;
        #1;
        chk("single s_ready idle", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        #1;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            check_beat("single", i, fld[i]);
            chk($sformatf("single s_ready %0d", i), 32'(s_ready), 32'(i == 10));
            tick();
        end
        chk("single idle tvalid", 32'(m_tvalid), 32'd0);
        chk("single idle s_ready", 32'(s_ready), 32'd1);

        // Backpressure with m_tready pattern 1,0,0,1.
        fill_seed(8'h20);
        s_data  = pack_fld();
        s_valid = 1'b1;
        tick();
        s_valid  = 1'b0;
        next_idx = 0;
        hs       = 0;
        cyc      = 0;
        bp_pat   = 4'b1001;
        while (next_idx < NUM_FIELDS && cyc < 80) begin
            m_tready = bp_pat[3 - (cyc % 4)];
            #1;
            check_beat("bp", next_idx, fld[next_idx]);
            if (m_tready) begin
                hs++;
                next_idx++;
            end
            cyc++;
            tick();
        end
        chk("bp handshakes", 32'(hs), 32'd11);
        chk("bp idle tvalid", 32'(m_tvalid), 32'd0);

        // Three back-to-back vectors, s_valid held high, m_tready high.
        m_tready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            fill_seed(8'h30 + 8'(v * 8'h40));
            vecs[v] = pack_fld();
            for (int k = 0; k < NUM_FIELDS; k++) exp_b2b[v*11 + k] = fld[k];
        end
        s_data  = vecs[0];
        s_valid = 1'b1;
        tick();
        for (int b = 0; b < 33; b++) begin
            if (b / 11 < 2) begin
                s_valid = 1'b1;
                s_data  = vecs[b/11 + 1];
            end else begin
                s_valid = 1'b0;
            end
            #1;
            check_beat("b2b", b % 11, exp_b2b[b]);
            chk($sformatf("b2b s_ready %0d", b), 32'(s_ready), 32'((b % 11) == 10));
            tick();
        end
        chk("b2b idle tvalid", 32'(m_tvalid), 32'd0);

        // All-ones vector: field 1 masked to 6 bits.
        s_data  = '1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            check_beat("ones", i, (i == 1) ? 8'h3F : 8'hFF);
            tick();
        end

        // Reset while idx = 5.
        fill_seed(8'h50);
        s_data  = pack_fld();
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        m_tready = 1'b0;
        #1;
        chk("midrst idx5 tuser", 32'(m_tuser), 32'd5);
        aresetn = 1'b0;
        #1;
        chk("midrst tvalid", 32'(m_tvalid), 32'd0);
        chk("midrst tlast",  32'(m_tlast),  32'd0);
        chk("midrst tuser",  32'(m_tuser),  32'd0);
        #1;
        aresetn = 1'b1;
        tick();
        chk("postrst tvalid", 32'(m_tvalid), 32'd0);
        chk("postrst s_ready", 32'(s_ready), 32'd1);
        fill_seed(8'h60);
        s_data   = pack_fld();
        s_valid  = 1'b1;
        m_tready = 1'b1;
        tick();
        s_valid = 1'b0;
        check_beat("postrst", 0, fld[0]);
        tick();
        check_beat("postrst", 1, fld[1]);
        for (int i = 2; i < NUM_FIELDS; i++) tick();

        // Buffer isolation: s_data churns while s_valid is low.
        fill_seed(8'h80);
        s_data  = pack_fld();
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            v_tmp  = {$urandom, $urandom, $urandom};
            s_data = v_tmp;
            #1;
            check_beat("iso", i, fld[i]);
            tick();
        end
        chk("iso idle tvalid", 32'(m_tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
